// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the serial code-entry lock.
// State encoding is fixed for the debug port.
package code_lock_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        CHG  = 2'd1,
        LOCK = 2'd2
    } state_e;

    function automatic int cnt_w(input int code_w);
        return $clog2(code_w + 1);
    endfunction

endpackage

// File: rtl/code_lock_fsm_entry_sreg.sv
// Entry shift register with saturating bit count and overflow flag.
// An entry is only usable when exactly CODE_W bits arrived.
module entry_sreg
    import code_lock_pkg::*;
#(
    parameter int CODE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              clear,
    output logic [CODE_W-1:0] shreg,
    output logic              valid_len
);

    localparam int CW = cnt_w(CODE_W);
    localparam logic [CW-1:0] FULL = CW'(CODE_W);

    logic [CW-1:0] cnt;
    logic          ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            shreg <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (bit_valid) begin
            shreg <= {shreg[CODE_W-2:0], bit_in};
            if (cnt == FULL) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign valid_len = (cnt == FULL) && !ovf;

endmodule

// File: rtl/code_lock_fsm.sv
// Programmable code lock: entry check, in-field code change, lockout.
// Pulses and state are registered; locked follows the LOCK state.
module code_lock_fsm
    import code_lock_pkg::*;
#(
    parameter int                CODE_W       = 4,
    parameter int                MAX_FAIL     = 3,
    parameter int                LOCK_CYCLES  = 16,
    parameter logic [CODE_W-1:0] DEFAULT_CODE = 4'b0101
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               bit_valid,
    input  logic               bit_in,
    input  logic               confirm,
    input  logic               change_req,
    output logic               unlock,
    output logic               fail,
    output logic               chg_ok,
    output logic               locked,
    output logic [STATE_W-1:0] state_o
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = $clog2(LOCK_CYCLES + 1);
    localparam logic [FW-1:0] MAXF  = FW'(MAX_FAIL);
    localparam logic [TW-1:0] LOCKT = TW'(LOCK_CYCLES);
    localparam logic [TW-1:0] T_ONE = TW'(1);

    localparam logic [STATE_W-1:0] S_IDLE = IDLE;
    localparam logic [STATE_W-1:0] S_CHG  = CHG;
    localparam logic [STATE_W-1:0] S_LOCK = LOCK;

    logic [STATE_W-1:0] state;
    logic [CODE_W-1:0]  code;
    logic [FW-1:0]      fail_cnt;
    logic [FW-1:0]      fail_nxt;
    logic [TW-1:0]      timer;
    logic [CODE_W-1:0]  shreg;
    logic               valid_len;
    logic               match;
    logic               active;
    logic               st_idle;
    logic               st_chg;
    logic               st_lock;

    assign st_idle  = (state == S_IDLE);
    assign st_chg   = (state == S_CHG);
    assign st_lock  = (state == S_LOCK);
    assign active   = !st_lock;
    assign match    = valid_len && (shreg == code);
    assign fail_nxt = fail_cnt + 1'b1;

    // Entry is frozen during lockout; confirm beats a same-cycle bit.
    entry_sreg #(
        .CODE_W(CODE_W)
    ) u_entry (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_valid(bit_valid && active),
        .bit_in   (bit_in),
        .clear    (confirm && active),
        .shreg    (shreg),
        .valid_len(valid_len)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            code     <= DEFAULT_CODE;
            fail_cnt <= '0;
            timer    <= '0;
            unlock   <= 1'b0;
            fail     <= 1'b0;
            chg_ok   <= 1'b0;
        end else begin
            unlock <= 1'b0;
            fail   <= 1'b0;
            chg_ok <= 1'b0;
            unique case (1'b1)
                st_idle: begin
                    if (confirm) begin
                        if (match) begin
                            fail_cnt <= '0;
                            if (change_req) begin
                                state <= S_CHG;
                            end else begin
                                unlock <= 1'b1;
                            end
                        end else begin
                            fail     <= 1'b1;
                            fail_cnt <= fail_nxt;
                            if (fail_nxt == MAXF) begin
                                state <= S_LOCK;
                                timer <= LOCKT;
                            end
                        end
                    end
                end
                st_chg: begin
                    if (confirm) begin
                        state <= S_IDLE;
                        if (valid_len) begin
                            code   <= shreg;
                            chg_ok <= 1'b1;
                        end else begin
                            fail <= 1'b1;
                        end
                    end
                end
                st_lock: begin
                    timer <= timer - 1'b1;
                    if (timer == T_ONE) begin
                        state    <= S_IDLE;
                        fail_cnt <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign locked  = st_lock;
    assign state_o = state;

endmodule
